wb_arbiter: RTL

Register-file write-port arbiter for the MIPS datapath: the writer side of the single-write-port register file. It merges two result producers into the one `write_reg`/`write_data`/`regWrite` port:

- the in-order pipeline writeback, which always has priority and is never stalled by this block except as described under starvation;
- the multi-cycle multiply/divide unit (MDU), whose results are buffered in a small FIFO and drained into idle writeback slots.

It also exports a busy mask so the hazard unit can stall readers of registers with pending MDU results.

---
 rtl/wb_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Register-file write-port arbiter. Merges the in-order pipeline
//            writeback (priority) with results from the multi-cycle
//            multiply/divide unit, which are buffered in a small FIFO and
//            drained into idle writeback slots. A starvation counter forces
//            a one-cycle pipeline stall so queued results cannot wait forever.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   1   clock, rising edge
//   reset       in   1   synchronous active-high reset
//   pipe_valid  in   1   pipeline writeback request
//   pipe_reg    in   5   pipeline destination register
//   pipe_data   in  32   pipeline result
//   mdu_valid   in   1   MDU result offered
//   mdu_reg     in   5   MDU destination register
//   mdu_data    in  32   MDU result
//   mdu_ready   out  1   FIFO can accept a result
//   write_reg   out  5   register-file write address (registered)
//   write_data  out 32   register-file write data (registered)
//   regWrite    out  1   register-file write enable (registered)
//   busy_mask   out 32   registers with a pending MDU result (bit 0 always 0)
//   stall_req   out  1   no pipeline writeback allowed next cycle (registered)
// ============================================================================
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_reg,
  input  logic [31:0] pipe_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        regWrite,
  output logic [31:0] busy_mask,
  output logic        stall_req
);

  localparam int c_ptr_w    = $clog2(DEPTH);
  localparam int c_cnt_w    = c_ptr_w + 1;
  localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);

  localparam logic [c_ptr_w-1:0]    c_ptr_one      = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0]    c_cnt_one      = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]    c_full         = c_cnt_w'(DEPTH);
  localparam logic [c_starve_w-1:0] c_starve_one   = c_starve_w'(1);
  localparam logic [c_starve_w-1:0] c_starve_limit = c_starve_w'(STARVE_LIMIT);

  // FIFO storage and bookkeeping
  logic [4:0]          r_fifo_reg  [DEPTH];
  logic [31:0]         r_fifo_data [DEPTH];
  logic [DEPTH-1:0]    r_fifo_vld;
  logic [c_ptr_w-1:0]  r_head;
  logic [c_ptr_w-1:0]  r_tail;
  logic [c_cnt_w-1:0]  r_count;

  logic [c_starve_w-1:0] r_starve_cnt;
  logic                  r_stall_req;
  logic                  r_reg_write;
  logic [4:0]            r_write_reg;
  logic [31:0]           r_write_data;

  logic                  w_empty;
  logic                  w_pipe_take;
  logic                  w_pop;
  logic                  w_push;
  logic [4:0]            w_head_reg;
  logic [31:0]           w_head_data;
  logic [c_starve_w-1:0] w_starve_next;
  logic [31:0]           w_busy;

  assign w_empty     = (r_count == '0);
  // While stall_req is high the pipeline must not write, so its request is
  // ignored and the slot falls through to the FIFO head.
  assign w_pipe_take = pipe_valid && (pipe_reg != 5'd0) && !r_stall_req;
  assign w_pop       = !w_pipe_take && !w_empty;
  // Ready comes from the registered count only: a full FIFO never accepts,
  // even in a cycle where it pops.
  assign mdu_ready   = (r_count != c_full);
  assign w_push      = mdu_valid && mdu_ready;

  assign w_head_reg    = r_fifo_reg[r_head];
  assign w_head_data   = r_fifo_data[r_head];
  assign w_starve_next = r_starve_cnt + c_starve_one;

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_fifo_vld[i]) begin
        w_busy[r_fifo_reg[i]] = 1'b1;
      end
    end
    w_busy[0] = 1'b0;
  end

  // Payload storage needs no reset; validity is tracked in r_fifo_vld.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_reg[r_tail]  <= mdu_reg;
      r_fifo_data[r_tail] <= mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fifo_vld   <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
      r_stall_req  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      // Pop clears before push sets; they never address the same slot
      // because a pop needs a non-empty FIFO and a push a non-full one.
      if (w_pop) begin
        r_fifo_vld[r_head] <= 1'b0;
        r_head             <= r_head + c_ptr_one;
      end
      if (w_push) begin
        r_fifo_vld[r_tail] <= 1'b1;
        r_tail             <= r_tail + c_ptr_one;
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_cnt_one;
      end

      // Write port: pipeline first, otherwise the FIFO head. A head entry
      // targeting r0 is consumed without a write; address/data then hold.
      if (w_pipe_take) begin
        r_reg_write  <= 1'b1;
        r_write_reg  <= pipe_reg;
        r_write_data <= pipe_data;
      end else if (w_pop && (w_head_reg != 5'd0)) begin
        r_reg_write  <= 1'b1;
        r_write_reg  <= w_head_reg;
        r_write_data <= w_head_data;
      end else begin
        r_reg_write  <= 1'b0;
      end

      // Starvation: count cycles the pipeline wins over a waiting entry.
      // Reaching the limit raises stall_req for one cycle, during which the
      // head pops and the counter clears.
      if (w_pop || w_empty) begin
        r_starve_cnt <= '0;
        r_stall_req  <= 1'b0;
      end else begin
        r_starve_cnt <= w_starve_next;
        r_stall_req  <= (w_starve_next == c_starve_limit);
      end
    end
  end

  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign regWrite   = r_reg_write;
  assign busy_mask  = w_busy;
  assign stall_req  = r_stall_req;

endmodule
`default_nettype wire
